// File: rtl/event_arbiter_if.sv
// Event offer channel: producer drives ev_valid/ev_id, consumer answers with ev_ready.
// Carries no state of its own.
interface event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;

    modport master (output ev_valid, output ev_id, input ev_ready);
    modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/event_arbiter.sv
// Edge-detecting event latch with round-robin offer; sig edge -> ev_valid two clocks later.
// Offer and ev_id hold until ev_ready; edges arriving meanwhile coalesce into pending/overflow.
module event_arbiter #(
    parameter int N_CH           = 4,
    parameter bit DETECT_NEGEDGE = 1'b0,
    parameter int ID_W           = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig,
    input  logic [N_CH-1:0] ch_en,
    input  logic            clr_ovf,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow,
    event_arbiter_if.master ev_if
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] curr_q, curr_d;
    logic [N_CH-1:0] past_q, past_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic [ID_W-1:0] ev_id_q, ev_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;

    logic [N_CH-1:0] edge_det;
    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] served;
    logic            handshake;
    logic [ID_W-1:0] pick_hi;
    logic [ID_W-1:0] pick_lo;
    logic            found_hi;

    assign edge_det  = DETECT_NEGEDGE ? (past_q & ~curr_q) : (curr_q & ~past_q);
    assign hit       = edge_det & ch_en;
    assign handshake = (state_q == OFFER) && ev_if.ev_ready;
    assign served    = handshake ? (N_CH'(1) << ev_id_q) : '0;

    // Round-robin: lowest pending index above last_grant wins, else lowest overall (wrap).
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                if (i > int'(last_grant_q)) begin
                    pick_hi  = ID_W'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        curr_d       = sig;
        past_d       = curr_q;
        // A fresh edge on the channel being served re-arms it instead of counting as lost.
        pending_d    = (pending_q & ~served) | hit;
        overflow_d   = (clr_ovf ? '0 : overflow_q) | (hit & pending_q & ~served);
        state_d      = state_q;
        ev_id_d      = ev_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d      = OFFER;
                    ev_id_d      = found_hi ? pick_hi : pick_lo;
                    last_grant_d = found_hi ? pick_hi : pick_lo;
                end
            end
            OFFER: begin
                if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            curr_q       <= '0;
            past_q       <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            ev_id_q      <= '0;
            last_grant_q <= ID_W'(N_CH - 1);
        end else begin
            state_q      <= state_d;
            curr_q       <= curr_d;
            past_q       <= past_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            ev_id_q      <= ev_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ev_if.ev_valid = (state_q == OFFER);
    assign ev_if.ev_id    = ev_id_q;
    assign pending        = pending_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of event channels (2..16).
REQ-002 Parameter DETECT_NEGEDGE, default 0; 0 = rising-edge events, 1 = falling-edge events, applies to all channels.
REQ-003 Parameter ID_W, default 2, width of ev_id; SHALL equal ceil(log2(N_CH)).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sig  input  N_CH  raw event levels; already in the clk domain.
REQ-007 ch_en  input  N_CH  per-channel enable; edges on disabled channels are dropped.
REQ-008 ev_ready  input  1  consumer accepts the offered event.
REQ-009 clr_ovf  input  1  clears all overflow flags.
REQ-010 ev_valid  output  1  an event is offered.
REQ-011 ev_id  output  ID_W  channel index of the offered event.
REQ-012 pending  output  N_CH  latched, unserved events.
REQ-013 overflow  output  N_CH  sticky per-channel lost-event flags.

Function
REQ-014 Per channel, sig SHALL be registered into curr then past; the edge is detected combinationally as past=0,curr=1 (or past=1,curr=0 when DETECT_NEGEDGE=1).
REQ-015 A detected edge on an enabled channel SHALL set pending[i] at the next posedge.
REQ-016 FSM states: IDLE, OFFER; IDLE->OFFER when any pending bit is set; OFFER->IDLE on the posedge where ev_valid && ev_ready; OFFER otherwise holds.
REQ-017 ev_valid SHALL be 1 exactly when in OFFER (registered output).
REQ-018 On IDLE->OFFER the grant SHALL be chosen round-robin: first set pending bit searching from last_grant+1 upward, wrapping N_CH-1 -> 0; ev_id and last_grant load that index.
REQ-019 ev_id SHALL be stable for the whole time ev_valid is high.
REQ-020 On handshake, pending[ev_id] SHALL clear, unless a new edge on that channel is detected in the same cycle, in which case pending stays 1 and overflow is not set.
REQ-021 An edge detected on channel i while pending[i]=1 and not being cleared that cycle SHALL set overflow[i]; pending stays 1 (events coalesce).
REQ-022 overflow bits SHALL stay set until rst or clr_ovf; clr_ovf with a simultaneous new overflow event SHALL leave that bit set.
REQ-023 Latency: sig change first sampled at posedge E0 -> pending set after E1 -> ev_valid high after E2.
REQ-024 After a handshake, ev_valid SHALL be low for at least one cycle (IDLE); maximum throughput is one event per 2 cycles.
REQ-025 Clearing ch_en[i] SHALL NOT clear an already set pending[i] or abort an offer in progress.

Reset
REQ-026 While rst is 1 at posedge: curr, past, pending, overflow = 0; state = IDLE; ev_valid = 0; ev_id = 0; last_grant = N_CH-1 (channel 0 has top priority first).
REQ-027 rst SHALL take priority over all other inputs, including a handshake in the same cycle; an offered event is discarded.
REQ-028 A sig level held at the active level across reset release SHALL produce exactly one event (edge regs restart at 0); with DETECT_NEGEDGE=1 a held-low level SHALL produce none.

Verification
REQ-029 Single event: N_CH=4, ch_en=4'hF, ev_ready=1, sig[2] 0->1 sampled at E0 -> ev_valid=1, ev_id=2 after E2, low after E3, pending=0.
REQ-030 Round-robin: sig[0],sig[1],sig[3] rise on the same cycle, ev_ready=1 -> served ids 0,1,3 in that order, each offer separated by one idle cycle.
REQ-031 Backpressure/overflow: ev_ready=0, two rising edges on sig[1] 4 cycles apart -> ev_valid held, ev_id=1 stable, overflow=4'b0010; ready=1 -> one handshake, pending=0, overflow stays until clr_ovf pulse.
REQ-032 Simultaneous: new edge on granted channel 2 in the handshake cycle -> pending[2] stays 1, overflow[2]=0, channel 2 re-offered only after other pending channels in round-robin order.
REQ-033 Reset mid-offer: ev_valid=1, ev_id=3, assert rst with ev_ready=1 -> after that posedge ev_valid=0, pending=0, overflow=0; next event on ch 3 and ch 0 together -> ch 0 served first.
REQ-034 Disabled channel: ch_en=4'b1110, edge on sig[0] -> pending stays 0, no ev_valid; DETECT_NEGEDGE=1 variant: falling edge on sig[1] -> ev_id=1.
